// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port synchronous RAM with per-bit write mask,
// valid-qualified reads with selectable latency (1 or 2 cycles), and a
// built-in sequencer that zeroes every word after reset and on request.
// While the sequencer runs, busy is high and all user reads and writes are
// dropped.

module ram_sdp_clr #(
    parameter int DATA_W  = 5,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // DEPTH widened by one bit so the range check also works when DEPTH
    // equals 2**ADDR_W (where DEPTH itself does not fit in ADDR_W bits).
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_addr;
    logic [ADDR_W-1:0]   clr_addr_next;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_wmask;

    logic                wr_in_range;
    logic                rd_in_range;
    logic                rd_go;
    logic [DATA_W-1:0]   rd_word;

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic                busy_q;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    // Out-of-range reads return zero instead of touching the array.
    assign rd_word = rd_in_range ? mem[rd_addr] : '0;

    // Sequencer state and sweep address; reset restarts the sweep at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Next-state logic plus selection of the single memory write port:
    // the sweep owns it in CLEAR, the user owns it in READY.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        mem_we        = 1'b0;
        mem_waddr     = wr_addr;
        mem_wdata     = wr_data;
        mem_wmask     = wr_mask;
        rd_go         = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
                mem_wmask = '1;
                if (clr_addr == LAST_ADDR) begin
                    state_next    = READY;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr + ADDR_W'(1);
                end
            end
            READY: begin
                mem_we = wr_en && wr_in_range;
                rd_go  = rd_en;
                if (clr_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    // Busy comes straight from a flop so it has no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b1;
        end else begin
            busy_q <= (state_next == CLEAR);
        end
    end

    assign busy = busy_q;

    // Masked memory write; the array has no reset, the sweep defines it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    // First read stage: captures the old word (read-first on collisions)
    // and holds its data between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;

            // Optional output register adding one cycle of read latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_valid = s2_valid;
            assign rd_data  = s2_data;
        end else begin : g_no_out_reg
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_clr.sv
// tb_ram_sdp_clr: drives two instances in lockstep (64 words / latency 1 and
// 40 words / latency 2) and compares every output each cycle against a
// behavioural model of the memory, the clear sweep and the read latency.

module tb_ram_sdp_clr;

    localparam int DW = 5;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_req;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_mask;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic          busy0, rd_valid0;
    logic [DW-1:0] rd_data0;
    logic          busy1, rd_valid1;
    logic [DW-1:0] rd_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(40), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    // Reference model: word array, remaining sweep cycles, and read results
    // tagged with the edge number on which they must appear.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] mem_m [2][64];
    int            busy_left [2];
    logic          exp_valid [2];
    logic [DW-1:0] exp_data [2];
    logic          exp_busy [2];
    pend_t         pend0 [$];
    pend_t         pend1 [$];
    int            edge_n = 0;

    function automatic int depthOf(input int i);
        return (i == 0) ? 64 : 40;
    endfunction

    function automatic int latOf(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic modelEdge();
        logic          res_v;
        logic [DW-1:0] res_d;
        pend_t         p;
        int            d;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            d     = depthOf(i);
            res_v = 1'b0;
            res_d = '0;
            if (rst) begin
                busy_left[i] = d;
                exp_valid[i] = 1'b0;
                exp_data[i]  = '0;
                if (i == 0) pend0.delete();
                else        pend1.delete();
            end else begin
                if (busy_left[i] > 0) begin
                    mem_m[i][d - busy_left[i]] = '0;
                    busy_left[i]--;
                end else begin
                    if (rd_en) begin
                        res_v = 1'b1;
                        res_d = (int'(rd_addr) < d) ? mem_m[i][rd_addr] : '0;
                    end
                    if (wr_en && (int'(wr_addr) < d)) begin
                        mem_m[i][wr_addr] = (mem_m[i][wr_addr] & ~wr_mask) | (wr_data & wr_mask);
                    end
                    if (clr_req) begin
                        busy_left[i] = d;
                    end
                end
                if (res_v) begin
                    p.due  = edge_n + latOf(i) - 1;
                    p.data = res_d;
                    if (i == 0) pend0.push_back(p);
                    else        pend1.push_back(p);
                end
                exp_valid[i] = 1'b0;
                if (i == 0) begin
                    if (pend0.size() > 0 && pend0[0].due == edge_n) begin
                        exp_valid[0] = 1'b1;
                        exp_data[0]  = pend0[0].data;
                        void'(pend0.pop_front());
                    end
                end else begin
                    if (pend1.size() > 0 && pend1[0].due == edge_n) begin
                        exp_valid[1] = 1'b1;
                        exp_data[1]  = pend1[0].data;
                        void'(pend1.pop_front());
                    end
                end
            end
            exp_busy[i] = rst || (busy_left[i] > 0);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at
    // the rising edge, and compare all outputs at the next falling edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [DW-1:0] wm, input logic re, input logic [AW-1:0] ra,
                                 input logic cr);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_mask = wm;
        rd_en   = re;
        rd_addr = ra;
        clr_req = cr;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("dut0.busy",     32'(busy0),     32'(exp_busy[0]));
        checkOutput("dut0.rd_valid", 32'(rd_valid0), 32'(exp_valid[0]));
        checkOutput("dut0.rd_data",  32'(rd_data0),  32'(exp_data[0]));
        checkOutput("dut1.busy",     32'(busy1),     32'(exp_busy[1]));
        checkOutput("dut1.rd_valid", 32'(rd_valid1), 32'(exp_valid[1]));
        checkOutput("dut1.rd_data",  32'(rd_data1),  32'(exp_data[1]));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic readCycle(input logic [AW-1:0] ra);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, ra, 1'b0);
    endtask

    task automatic writeCycle(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        applyStimulus(1'b1, wa, wd, wm, 1'b0, '0, 1'b0);
    endtask

    // Counts falling-edge samples with busy high, bounded so a stuck busy
    // shows up as a wrong count instead of a hang.
    task automatic countBusy(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy0) c0++;
            if (busy1) c1++;
            if (!busy0 && !busy1) break;
            idleCycle();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        int c1;
        rst     = 1'b1;
        clr_req = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        @(negedge clk);
        repeat (3) idleCycle();

        // Power-up sweep length.
        rst = 1'b0;
        countBusy(c0, c1);
        checkOutput("sweep_len0", 32'(c0), 32'd64);
        checkOutput("sweep_len1", 32'(c1), 32'd40);

        // Every word reads back zero after the sweep (back-to-back reads).
        for (int a = 0; a < 64; a++) readCycle(AW'(a));
        idleCycle();
        idleCycle();

        // Masked write.
        writeCycle(6'd10, 5'h1F, 5'h1F);
        writeCycle(6'd10, 5'h00, 5'h05);
        readCycle(6'd10);
        checkOutput("masked0", 32'(rd_data0), 32'h1A);
        idleCycle();
        checkOutput("masked1", 32'(rd_data1), 32'h1A);

        // Read/write collision returns old contents.
        writeCycle(6'd3, 5'h07, 5'h1F);
        applyStimulus(1'b1, 6'd3, 5'h15, 5'h1F, 1'b1, 6'd3, 1'b0);
        checkOutput("collide_old0", 32'(rd_data0), 32'h07);
        readCycle(6'd3);
        checkOutput("collide_new0", 32'(rd_data0), 32'h15);
        checkOutput("collide_old1", 32'(rd_data1), 32'h07);
        idleCycle();
        checkOutput("collide_new1", 32'(rd_data1), 32'h15);

        // Streaming reads.
        for (int a = 0; a < 4; a++) writeCycle(AW'(a), DW'(a + 1), 5'h1F);
        for (int a = 0; a < 4; a++) begin
            readCycle(AW'(a));
            if (a > 0) checkOutput("stream1", 32'(rd_data1), 32'(a));
        end
        idleCycle();
        checkOutput("stream1_last", 32'(rd_data1), 32'd4);
        checkOutput("stream1_lastv", 32'(rd_valid1), 32'd1);
        idleCycle();
        checkOutput("stream1_end", 32'(rd_valid1), 32'd0);

        // Highest in-range words.
        writeCycle(6'd39, 5'h11, 5'h1F);
        writeCycle(6'd63, 5'h12, 5'h1F);
        readCycle(6'd39);
        readCycle(6'd63);
        idleCycle();
        idleCycle();

        // Clear request with a read in the same cycle, then gated traffic.
        writeCycle(6'd5, 5'h1F, 5'h1F);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b1);
        checkOutput("clr_rd0", 32'(rd_data0), 32'h1F);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 6'd5, 5'h0A, 5'h1F, 1'b1, 6'd5, 1'b0);
            checkOutput("gated_valid0", 32'(rd_valid0), 32'd0);
            if (k == 0) checkOutput("clr_rd1", 32'(rd_data1), 32'h1F);
        end
        countBusy(c0, c1);
        checkOutput("clr_rest0", 32'(c0), 32'd54);
        checkOutput("clr_rest1", 32'(c1), 32'd30);
        readCycle(6'd5);
        checkOutput("cleared0", 32'(rd_data0), 32'd0);
        idleCycle();
        checkOutput("cleared1", 32'(rd_data1), 32'd0);
        checkOutput("cleared1v", 32'(rd_valid1), 32'd1);

        // Out-of-range address on the 40-word instance.
        writeCycle(6'd10, 5'h1A, 5'h1F);
        writeCycle(6'd45, 5'h16, 5'h1F);
        readCycle(6'd10);
        readCycle(6'd45);
        checkOutput("oor_wr0", 32'(rd_data0), 32'h16);
        idleCycle();
        checkOutput("oor_rd1", 32'(rd_data1), 32'd0);
        checkOutput("oor_rd1v", 32'(rd_valid1), 32'd1);

        // Reset in the middle of a sweep restarts it.
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        repeat (20) idleCycle();
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        countBusy(c0, c1);
        checkOutput("resweep_len0", 32'(c0), 32'd64);
        checkOutput("resweep_len1", 32'(c1), 32'd40);

        // Random traffic, including occasional clear requests.
        for (int k = 0; k < 500; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom),
                          DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                          1'($urandom_range(0, 79) == 0));
        end
        repeat (3) idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
